// File: rtl/pattern_run_controller.sv
// Sequences a pattern_generator run (reset, run N periods, drain) and checks every lane
// against the generator output delayed to the lane latency.
module pattern_run_controller #(
  parameter int IO_SIZE_G      = 3,
  parameter int NUM_LANES_G    = 3,
  parameter int SEQ_LEN_G      = 12,
  parameter int RST_CYCLES_G   = 4,
  parameter int LANE_LATENCY_G = 2,
  parameter int CNT_W_G        = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             abort_i,
  input  logic [15:0]                      run_periods_i,
  output logic                             gen_rst_o,
  input  logic [IO_SIZE_G-1:0]             gen_data_i,
  input  logic [NUM_LANES_G*IO_SIZE_G-1:0] lanes_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             aborted_o,
  output logic [NUM_LANES_G-1:0]           lane_err_o,
  output logic [CNT_W_G-1:0]               err_count_o,
  output logic                             gen_fault_o
);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int PH_MAX = (SEQ_LEN_G > RST_CYCLES_G) ?
                          ((SEQ_LEN_G > LANE_LATENCY_G + 1) ? SEQ_LEN_G : LANE_LATENCY_G + 1) :
                          ((RST_CYCLES_G > LANE_LATENCY_G + 1) ? RST_CYCLES_G : LANE_LATENCY_G + 1);
  localparam int PH_W = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0]    PH_ONE     = PH_W'(1);
  localparam logic [PH_W-1:0]    RST_LAST   = PH_W'(RST_CYCLES_G - 1);
  localparam logic [PH_W-1:0]    SEQ_LAST   = PH_W'(SEQ_LEN_G - 1);
  localparam logic [PH_W-1:0]    DRAIN_LAST = PH_W'(LANE_LATENCY_G);
  localparam logic [CNT_W_G-1:0] CNT_ONE    = CNT_W_G'(1);

  state_t      state, state_next;
  logic [PH_W-1:0] ph_cnt, ph_next;
  logic [15:0] per_cnt, per_next, run_periods;
  logic        start_acc, abort_take, pipe_clr;

  always_comb begin
    state_next = state;
    ph_next    = ph_cnt;
    per_next   = per_cnt;
    start_acc  = 1'b0;
    abort_take = 1'b0;
    if (abort_i) begin
      if (state != S_IDLE) begin
        abort_take = 1'b1;
        state_next = S_IDLE;
        ph_next    = '0;
      end
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start_i) begin
          start_acc  = 1'b1;
          state_next = S_RESET;
          ph_next    = '0;
          per_next   = '0;
        end
        S_RESET: if (ph_cnt == RST_LAST) begin
          state_next = S_RUN;
          ph_next    = '0;
        end else ph_next = ph_cnt + PH_ONE;
        S_RUN: if (ph_cnt == SEQ_LAST) begin
          ph_next = '0;
          // zero programmed periods means the run only ends on abort
          if (run_periods != 16'd0 && per_cnt + 16'd1 == run_periods) state_next = S_DRAIN;
          else per_next = per_cnt + 16'd1;
        end else ph_next = ph_cnt + PH_ONE;
        S_DRAIN: if (ph_cnt == DRAIN_LAST) begin
          state_next = S_DONE;
          ph_next    = '0;
        end else ph_next = ph_cnt + PH_ONE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign pipe_clr = start_acc | abort_take;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      ph_cnt      <= '0;
      per_cnt     <= '0;
      run_periods <= '0;
      gen_rst_o   <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      aborted_o   <= 1'b0;
    end else begin
      state     <= state_next;
      ph_cnt    <= ph_next;
      per_cnt   <= per_next;
      if (start_acc) run_periods <= run_periods_i;
      gen_rst_o <= (state_next != S_RUN);
      busy_o    <= (state_next == S_RESET) || (state_next == S_RUN) || (state_next == S_DRAIN);
      done_o    <= (state_next == S_DONE);
      if (abort_take) aborted_o <= 1'b1;
      else if (start_acc) aborted_o <= 1'b0;
    end
  end

  // sample_vld lags RUN by one cycle to line up with the generator's output register
  logic                 sample_vld, exp_vld;
  logic [IO_SIZE_G-1:0] exp_word;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         sample_vld <= 1'b0;
    else if (pipe_clr) sample_vld <= 1'b0;
    else               sample_vld <= (state == S_RUN);
  end

  generate
    if (LANE_LATENCY_G == 0) begin : g_nodly
      assign exp_word = gen_data_i;
      assign exp_vld  = sample_vld;
    end else begin : g_dly
      logic [IO_SIZE_G-1:0] data_pipe [LANE_LATENCY_G];
      logic                 vld_pipe  [LANE_LATENCY_G];
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || pipe_clr) begin
          for (int i = 0; i < LANE_LATENCY_G; i++) begin
            data_pipe[i] <= '0;
            vld_pipe[i]  <= 1'b0;
          end
        end else begin
          data_pipe[0] <= gen_data_i;
          vld_pipe[0]  <= sample_vld;
          for (int i = 1; i < LANE_LATENCY_G; i++) begin
            data_pipe[i] <= data_pipe[i-1];
            vld_pipe[i]  <= vld_pipe[i-1];
          end
        end
      end
      assign exp_word = data_pipe[LANE_LATENCY_G-1];
      assign exp_vld  = vld_pipe[LANE_LATENCY_G-1];
    end
  endgenerate

  logic [NUM_LANES_G-1:0] mism;
  always_comb begin
    mism = '0;
    for (int k = 0; k < NUM_LANES_G; k++)
      mism[k] = (lanes_i[k*IO_SIZE_G +: IO_SIZE_G] != exp_word);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_err_o  <= '0;
      err_count_o <= '0;
      gen_fault_o <= 1'b0;
    end else if (start_acc) begin
      lane_err_o  <= '0;
      err_count_o <= '0;
      gen_fault_o <= 1'b0;
    end else if (exp_vld) begin
      lane_err_o <= lane_err_o | mism;
      if ((|mism) && (err_count_o != '1)) err_count_o <= err_count_o + CNT_ONE;
      if (&mism) gen_fault_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pattern_run_controller.sv
// Directed bench: a counting generator model feeds lanes through a 2-cycle delay,
// with per-lane corruption masks to provoke lane errors and generator faults.
module tb_pattern_run_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] run_periods_i = 16'd0;
  logic        gen_rst_o;
  logic [2:0]  gen_data;
  logic [8:0]  lanes;
  logic        busy_o, done_o, aborted_o, gen_fault_o;
  logic [2:0]  lane_err_o;
  logic [3:0]  err_count_o;
  logic [2:0]  lane_mask = 3'b000;
  logic [2:0]  lp1, lp2;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pattern_run_controller #(
    .IO_SIZE_G(3), .NUM_LANES_G(3), .SEQ_LEN_G(12),
    .RST_CYCLES_G(4), .LANE_LATENCY_G(2), .CNT_W_G(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .abort_i(abort_i),
    .run_periods_i(run_periods_i), .gen_rst_o(gen_rst_o), .gen_data_i(gen_data),
    .lanes_i(lanes), .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o),
    .lane_err_o(lane_err_o), .err_count_o(err_count_o), .gen_fault_o(gen_fault_o)
  );

  // generator model plus two-cycle lane delay
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_data <= 3'd0; lp1 <= 3'd0; lp2 <= 3'd0;
    end else begin
      gen_data <= gen_rst_o ? 3'd0 : gen_data + 3'd1;
      lp1 <= gen_data;
      lp2 <= lp1;
    end
  end

  always_comb begin
    lanes = '0;
    for (int k = 0; k < 3; k++)
      lanes[k*3 +: 3] = lp2 ^ (lane_mask[k] ? 3'b101 : 3'b000);
  end

  task automatic pulse_start(input logic [15:0] n);
    run_periods_i = n;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_run_start(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      if (gen_rst_o === 1'b0) break;
      @(negedge clk);
    end
    checks++;
    if (gen_rst_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_run_start: gen_rst_o=%b required 0 within 50 cycles", name, gen_rst_o);
    end
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (done_o === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (done_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: done_o=%b required 1 within 200 cycles", name, done_o);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (gen_rst_o !== 1'b1) begin errors++; $display("FAIL reset_gen_rst: got %b want 1", gen_rst_o); end
    checks++; if ({busy_o, done_o, aborted_o, gen_fault_o} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy_o, done_o, aborted_o, gen_fault_o}); end
    checks++; if (lane_err_o !== 3'b000 || err_count_o !== 4'd0) begin errors++; $display("FAIL reset_errs: lane_err=%b count=%0d want 000/0", lane_err_o, err_count_o); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (gen_rst_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: gen_rst=%b busy=%b want 1/0", gen_rst_o, busy_o); end
  endtask

  task automatic test_nominal();
    int low = 0, pre = 0, post = 0;
    pulse_start(16'd2);
    for (int i = 0; i < 200; i++) begin
      if (done_o === 1'b1) break;
      if (gen_rst_o === 1'b0) low++;
      else if (busy_o === 1'b1 && low == 0) pre++;
      else if (busy_o === 1'b1) post++;
      @(negedge clk);
    end
    checks++; if (pre != 4) begin errors++; $display("FAIL nominal_reset_len: got %0d want 4", pre); end
    checks++; if (low != 24) begin errors++; $display("FAIL nominal_run_len: got %0d want 24", low); end
    checks++; if (post != 3) begin errors++; $display("FAIL nominal_drain_len: got %0d want 3", post); end
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || gen_rst_o !== 1'b1) begin errors++; $display("FAIL nominal_done: done=%b busy=%b gen_rst=%b want 1/0/1", done_o, busy_o, gen_rst_o); end
    checks++; if (lane_err_o !== 3'b000 || err_count_o !== 4'd0 || gen_fault_o !== 1'b0) begin errors++; $display("FAIL nominal_errs: lane_err=%b count=%0d fault=%b want 000/0/0", lane_err_o, err_count_o, gen_fault_o); end
  endtask

  task automatic test_single_lane();
    pulse_start(16'd2);
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL rearm_from_done: done=%b busy=%b want 0/1", done_o, busy_o); end
    wait_run_start("single");
    repeat (5) @(negedge clk);
    lane_mask = 3'b010;
    repeat (3) @(negedge clk);
    lane_mask = 3'b000;
    wait_done("single");
    checks++; if (lane_err_o !== 3'b010) begin errors++; $display("FAIL single_lane_err: got %b want 010", lane_err_o); end
    checks++; if (err_count_o !== 4'd3) begin errors++; $display("FAIL single_count: got %0d want 3", err_count_o); end
    checks++; if (gen_fault_o !== 1'b0) begin errors++; $display("FAIL single_fault: got %b want 0", gen_fault_o); end
  endtask

  task automatic test_gen_fault();
    pulse_start(16'd1);
    checks++; if (lane_err_o !== 3'b000 || err_count_o !== 4'd0) begin errors++; $display("FAIL fault_clear_on_start: lane_err=%b count=%0d want 000/0", lane_err_o, err_count_o); end
    wait_run_start("fault");
    repeat (6) @(negedge clk);
    lane_mask = 3'b111;
    @(negedge clk);
    lane_mask = 3'b000;
    wait_done("fault");
    checks++; if (lane_err_o !== 3'b111) begin errors++; $display("FAIL fault_lane_err: got %b want 111", lane_err_o); end
    checks++; if (err_count_o !== 4'd1) begin errors++; $display("FAIL fault_count: got %0d want 1", err_count_o); end
    checks++; if (gen_fault_o !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b want 1", gen_fault_o); end
  endtask

  task automatic test_abort();
    pulse_start(16'd2);
    wait_run_start("abort");
    repeat (4) @(negedge clk);
    lane_mask = 3'b001;
    @(negedge clk);
    lane_mask = 3'b000;
    repeat (2) @(negedge clk);
    abort_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    start_i = 1'b0;
    checks++; if (gen_rst_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL abort_idle: gen_rst=%b busy=%b done=%b want 1/0/0", gen_rst_o, busy_o, done_o); end
    checks++; if (aborted_o !== 1'b1) begin errors++; $display("FAIL abort_flag: got %b want 1", aborted_o); end
    lane_mask = 3'b111;
    repeat (5) @(negedge clk);
    lane_mask = 3'b000;
    checks++; if (lane_err_o !== 3'b001 || err_count_o !== 4'd1 || gen_fault_o !== 1'b0) begin errors++; $display("FAIL abort_hold: lane_err=%b count=%0d fault=%b want 001/1/0", lane_err_o, err_count_o, gen_fault_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_start_priority: busy=%b want 0", busy_o); end
    pulse_start(16'd1);
    checks++; if (aborted_o !== 1'b0 || lane_err_o !== 3'b000 || err_count_o !== 4'd0) begin errors++; $display("FAIL abort_restart_clear: aborted=%b lane_err=%b count=%0d want 0/000/0", aborted_o, lane_err_o, err_count_o); end
    wait_done("abort_restart");
  endtask

  task automatic test_busy_start_ignored();
    int low = 0;
    pulse_start(16'd1);
    for (int i = 0; i < 100; i++) begin
      if (done_o === 1'b1) break;
      if (gen_rst_o === 1'b0) low++;
      if (i == 2 || i == 8) begin start_i = 1'b1; run_periods_i = 16'd5; end
      else start_i = 1'b0;
      @(negedge clk);
    end
    start_i = 1'b0;
    checks++; if (low != 12) begin errors++; $display("FAIL busy_start_run_len: got %0d want 12", low); end
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL busy_start_done: got %b want 1", done_o); end
  endtask

  task automatic test_infinite_sat();
    int low = 0;
    pulse_start(16'd0);
    wait_run_start("infinite");
    for (int i = 0; i < 1200; i++) begin
      if (gen_rst_o === 1'b0) low++;
      if (i == 10) lane_mask = 3'b001;
      if (i == 30) lane_mask = 3'b000;
      @(negedge clk);
    end
    checks++; if (low != 1200) begin errors++; $display("FAIL infinite_run_len: got %0d want 1200", low); end
    checks++; if (busy_o !== 1'b1 || gen_rst_o !== 1'b0) begin errors++; $display("FAIL infinite_still_running: busy=%b gen_rst=%b want 1/0", busy_o, gen_rst_o); end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    checks++; if (err_count_o !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d want 15", err_count_o); end
    checks++; if (lane_err_o !== 3'b001 || aborted_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL infinite_abort: lane_err=%b aborted=%b busy=%b want 001/1/0", lane_err_o, aborted_o, busy_o); end
  endtask

  task automatic test_async_reset();
    pulse_start(16'd2);
    wait_run_start("async");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (gen_rst_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL async_reset_immediate: gen_rst=%b busy=%b want 1/0", gen_rst_o, busy_o); end
    checks++; if (aborted_o !== 1'b0 || err_count_o !== 4'd0 || lane_err_o !== 3'b000) begin errors++; $display("FAIL async_reset_clear: aborted=%b count=%0d lane_err=%b want 0/0/000", aborted_o, err_count_o, lane_err_o); end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (gen_rst_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL async_reset_idle: gen_rst=%b done=%b busy=%b want 1/0/0", gen_rst_o, done_o, busy_o); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_single_lane();
    test_gen_fault();
    test_abort();
    test_busy_start_ignored();
    test_infinite_sat();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
